// File: rtl/sramdp_fifo_pkg.sv
// Shared constants and helpers for the dual-port SRAM FIFO controller.
package sramdp_fifo_pkg;

  localparam int SRAM_RD_LAT = 1;
  localparam int PF_DEPTH    = 2;

  // Occupancy spans SRAM depth plus the prefetch entries, so it needs two extra bits.
  function automatic int cnt_width(input int wordswd);
    return wordswd + 2;
  endfunction

endpackage

// File: rtl/sramdp_fifo_pfbuf.sv
// Two-entry prefetch/skid buffer holding SRAM read data in front of the pop port.
module sramdp_fifo_pfbuf #(
  parameter int BITS = 19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            cap,
  input  logic [BITS-1:0] cap_data,
  input  logic            pop,
  output logic [1:0]      occ,
  output logic [BITS-1:0] head
);

  logic [BITS-1:0] ent0;
  logic [BITS-1:0] ent1;
  logic            do_pop;

  assign do_pop = pop && (occ != 2'd0);
  assign head   = ent0;

  // ent0 is always the head; a capture lands in the first free slot after any shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (flush) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({cap, do_pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= cap_data;
          else             ent1 <= cap_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= cap_data;
          end else begin
            ent0 <= ent1;
            ent1 <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sramdp_fifo_ctrl.sv
// Synchronous FIFO built on one dual-port SRAM (port A write, port B read) plus a prefetch buffer.
// Optional build macro SRAMDP_FIFO_BYPASS_EN lets pushes into an empty FIFO skip the SRAM.
module sramdp_fifo_ctrl
  import sramdp_fifo_pkg::*;
#(
  parameter int WORDSWD = 10,
  parameter int BITS    = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [BITS-1:0]    in_data,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [BITS-1:0]    out_data,
  output logic [WORDSWD+1:0] count,
  output logic               sram_cena,
  output logic               sram_gwena,
  output logic [WORDSWD-1:0] sram_aa,
  output logic [BITS-1:0]    sram_da,
  output logic               sram_cenb,
  output logic               sram_gwenb,
  output logic [WORDSWD-1:0] sram_ab,
  input  logic [BITS-1:0]    sram_qb
);

  localparam int CW = cnt_width(WORDSWD);

  logic [WORDSWD-1:0] wptr;
  logic [WORDSWD-1:0] rptr;
  logic [WORDSWD:0]   sram_cnt;
  logic               inflight;
  logic               ready_q;
  logic [1:0]         buf_occ;
  logic               push_fire;
  logic               pop_fire;
  logic               to_buf;
  logic               to_sram;
  logic               rd_issue;
  logic               cap;
  logic [BITS-1:0]    cap_data;

  // sram_cnt never exceeds DEPTH, so its top bit alone marks a full SRAM.
  assign in_rdy    = ready_q && !sram_cnt[WORDSWD] && !flush;
  assign push_fire = in_vld && in_rdy;
  assign pop_fire  = out_vld && out_rdy && !flush;

`ifdef SRAMDP_FIFO_BYPASS_EN
  assign to_buf = push_fire && (sram_cnt == '0) && !inflight && (buf_occ < 2'd2);
`else
  assign to_buf = 1'b0;
`endif
  assign to_sram = push_fire && !to_buf;

  // A slot freed by this cycle's pop counts as free, which keeps the pop side at one word per cycle.
  assign rd_issue = !flush && (sram_cnt != '0) &&
                    ((({1'b0, buf_occ} + {2'b00, inflight}) < 3'(PF_DEPTH)) || pop_fire);

  assign sram_cena  = !to_sram;
  assign sram_gwena = !to_sram;
  assign sram_aa    = to_sram ? wptr : '0;
  assign sram_da    = to_sram ? in_data : '0;
  assign sram_cenb  = !rd_issue;
  assign sram_gwenb = 1'b1;
  assign sram_ab    = rd_issue ? rptr : '0;

  assign cap      = (inflight && !flush) || to_buf;
  assign cap_data = to_buf ? in_data : sram_qb;

  assign out_vld = (buf_occ != 2'd0);
  assign count   = CW'(sram_cnt) + CW'(buf_occ) + CW'(inflight);

  // Pointers wrap naturally at DEPTH; flush discards any in-flight read so its data is never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (flush) begin
        wptr     <= '0;
        rptr     <= '0;
        sram_cnt <= '0;
        inflight <= 1'b0;
      end else begin
        if (to_sram)  wptr <= wptr + 1'b1;
        if (rd_issue) rptr <= rptr + 1'b1;
        case ({to_sram, rd_issue})
          2'b10:   sram_cnt <= sram_cnt + 1'b1;
          2'b01:   sram_cnt <= sram_cnt - 1'b1;
          default: ;
        endcase
        inflight <= rd_issue;
      end
    end
  end

  sramdp_fifo_pfbuf #(
    .BITS(BITS)
  ) u_pfbuf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .cap      (cap),
    .cap_data (cap_data),
    .pop      (pop_fire),
    .occ      (buf_occ),
    .head     (out_data)
  );

endmodule

// File: tb/tb_sramdp_fifo_ctrl.sv
// Scoreboard bench for sramdp_fifo_ctrl with a behavioural dual-port SRAM; honours SRAMDP_FIFO_BYPASS_EN.
module tb_sramdp_fifo_ctrl;

  localparam int WORDSWD = 3;
  localparam int BITS    = 8;
  localparam int DEPTH   = 8;
`ifdef SRAMDP_FIFO_BYPASS_EN
  localparam int EXP_VLD_EDGE = 0;
`else
  localparam int EXP_VLD_EDGE = 2;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic               in_vld = 1'b0;
  logic               in_rdy;
  logic [BITS-1:0]    in_data = '0;
  logic               out_vld;
  logic               out_rdy = 1'b0;
  logic [BITS-1:0]    out_data;
  logic [WORDSWD+1:0] count;
  logic               sram_cena, sram_gwena, sram_cenb, sram_gwenb;
  logic [WORDSWD-1:0] sram_aa, sram_ab;
  logic [BITS-1:0]    sram_da;
  logic [BITS-1:0]    sram_qb;

  logic [BITS-1:0] mem [DEPTH];
  bit              pending [DEPTH];
  logic [BITS-1:0] expQ [$];
  int              cmpCount = 0;
  int              errCount = 0;
  int              popsSeen = 0;

  always #5 clk = ~clk;

  sramdp_fifo_ctrl #(.WORDSWD(WORDSWD), .BITS(BITS)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .count(count),
    .sram_cena(sram_cena), .sram_gwena(sram_gwena), .sram_aa(sram_aa), .sram_da(sram_da),
    .sram_cenb(sram_cenb), .sram_gwenb(sram_gwenb), .sram_ab(sram_ab), .sram_qb(sram_qb)
  );

  // Behavioural SRAM macro: one-cycle read latency on port B.
  always @(posedge clk) begin
    if (!sram_cena && !sram_gwena) mem[sram_aa] <= sram_da;
    if (!sram_cenb) sram_qb <= mem[sram_ab];
  end

  // An address may be read only after its write edge, and only once per write.
  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      foreach (pending[i]) pending[i] <= 1'b0;
    end else begin
      if (!sram_cena && !sram_gwena) pending[sram_aa] <= 1'b1;
      if (!sram_cenb) pending[sram_ab] <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle starting just after a rising edge; expected words enter the queue at the edge.
  task automatic applyStimulus(input logic v, input logic [BITS-1:0] d, input logic r, input logic f,
                               output logic acc, output logic vldSeen);
    in_vld  = v;
    in_data = d;
    out_rdy = r;
    flush   = f;
    @(negedge clk);
    acc     = in_vld && in_rdy;
    vldSeen = out_vld;
    @(posedge clk);
    if (f) expQ.delete();
    else if (acc) expQ.push_back(d);
    #1;
  endtask

  // Monitor: occupancy, SRAM read legality and popped data against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("count", 32'(count), expQ.size());
      checkOutput("count_max", 32'(count <= 10), 1);
      if (expQ.size() >= DEPTH + 2) checkOutput("in_rdy_full", 32'(in_rdy), 0);
      if (expQ.size() == 0) checkOutput("empty_vld", 32'(out_vld), 0);
      if (flush) begin
        checkOutput("flush_in_rdy", 32'(in_rdy), 0);
        checkOutput("flush_cen", {30'd0, sram_cena, sram_cenb}, 3);
      end
      if (!sram_cenb) begin
        checkOutput("rd_written", 32'(pending[sram_ab]), 1);
        if (!sram_cena && !sram_gwena) checkOutput("rd_wr_collide", 32'(sram_aa == sram_ab), 0);
      end
      if (out_vld && out_rdy && !flush) begin
        if (expQ.size() == 0) begin
          checkOutput("pop_on_empty", 32'(out_vld), 0);
        end else begin
          checkOutput("pop_data", 32'(out_data), 32'(expQ.pop_front()));
          popsSeen++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic acc, ov;
    int   accepted, lat, p0, cycles;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_rdy", 32'(in_rdy), 0);
    checkOutput("rst_out_vld", 32'(out_vld), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_cen", {28'd0, sram_cena, sram_cenb, sram_gwena, sram_gwenb}, 15);
    checkOutput("rst_addr", {24'd0, sram_aa, sram_ab, 2'd0}, 0);
    checkOutput("rst_da", 32'(sram_da), 0);
    #2 rst = 1'b0;
    #1 checkOutput("rel_in_rdy_0", 32'(in_rdy), 0);
    @(posedge clk);
    #1 checkOutput("rel_in_rdy_1", 32'(in_rdy), 1);

    $display("[TB] single word latency");
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, acc, ov);
    checkOutput("t1_accept", 32'(acc), 1);
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
      if (ov && lat < 0) lat = k;
    end
    checkOutput("t1_vld_edge", lat, EXP_VLD_EDGE);
    checkOutput("t1_count", 32'(count), 0);

    $display("[TB] fill to full");
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, acc, ov);
      accepted += int'(acc);
    end
    checkOutput("t2_accepted", accepted, 10);
    checkOutput("t2_in_rdy", 32'(in_rdy), 0);
    checkOutput("t2_count", 32'(count), 10);
    checkOutput("t2_sram_cnt", 32'(dut.sram_cnt), 8);

    $display("[TB] streaming with pointer wrap");
    p0 = popsSeen;
    accepted = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 8'(12 + i), 1'b1, 1'b0, acc, ov);
      accepted += int'(acc);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
    checkOutput("t3_pops", popsSeen - p0, 10 + accepted);
    checkOutput("t3_count", 32'(count), 0);

    $display("[TB] flush with read in flight");
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, acc, ov);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, acc, ov);
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, acc, ov);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc, ov);
    checkOutput("t4_count3", 32'(count), 3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
    checkOutput("t4_inflight", 32'(dut.inflight), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, acc, ov);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
    checkOutput("t4_vld_after", 32'(ov), 0);
    checkOutput("t4_count0", 32'(count), 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
    checkOutput("t4_no_capture", 32'(ov), 0);
    p0 = popsSeen;
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, acc, ov);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
    checkOutput("t4_pop55", popsSeen - p0, 1);

    $display("[TB] random traffic");
    p0 = popsSeen;
    cycles = 0;
    while ((popsSeen - p0) < 10000 && cycles < 60000) begin
      applyStimulus(1'($urandom_range(0, 99) < 70), 8'($urandom), 1'($urandom_range(0, 99) < 60),
                    1'($urandom_range(0, 999) == 0), acc, ov);
      cycles++;
    end
    checkOutput("t5_words", 32'((popsSeen - p0) >= 10000), 1);

    $display("[TB] reset mid-burst");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'($urandom_range(0, 1)), 1'b0, acc, ov);
    #2 rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("t6_in_rdy", 32'(in_rdy), 0);
    checkOutput("t6_out_vld", 32'(out_vld), 0);
    checkOutput("t6_count", 32'(count), 0);
    checkOutput("t6_out_data", 32'(out_data), 0);
    checkOutput("t6_cen", {29'd0, sram_cena, sram_gwena, sram_cenb}, 7);
    checkOutput("t6_addr_da", {16'd0, 2'd0, sram_aa, sram_ab, sram_da}, 0);
    in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 checkOutput("t6_rel_rdy0", 32'(in_rdy), 0);
    @(posedge clk);
    #1 checkOutput("t6_rel_rdy1", 32'(in_rdy), 1);
    p0 = popsSeen;
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, acc, ov);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
    checkOutput("t6_pop77", popsSeen - p0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
